// File: rtl/set_cmd_loader.sv
// Purpose: front end of the SET circle-coverage engine. It takes a 6-byte command packet,
//          loads central/radius/mode into SET, starts SET, and returns one result per packet.
// Latency: last byte -> set_en 2 cycles; set_valid -> res_valid 1 cycle; timeout after TIMEOUT
//          WAIT cycles (res_valid TIMEOUT+1 cycles after set_en).
// Backpressure: in_ready is high only in COLLECT. A result is held until res_ready, and the
//          next packet is accepted only after the result has been taken.
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   in_valid/in_ready   byte-wide command stream, in_data carries the bytes
//   set_en              one-cycle start pulse to SET
//   set_central         {x1,y1,x2,y2,x3,y3}
//   set_radius          {r1,r2,r3}
//   set_mode            SET mode
//   set_busy            SET status, monitored only
//   set_valid/set_cand  SET result (valid is a level) and candidate count
//   res_valid/res_ready result handshake; res_count and res_err (00 ok, 01 range, 10 timeout)
//   busy                high whenever the loader is not collecting bytes
module set_cmd_loader #(
  parameter int TIMEOUT   = 127,
  parameter bit CHECK_RNG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        set_en,
  output logic [23:0] set_central,
  output logic [11:0] set_radius,
  output logic [1:0]  set_mode,
  input  logic        set_busy,
  input  logic        set_valid,
  input  logic [7:0]  set_cand,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_count,
  output logic [1:0]  res_err,
  output logic        busy
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_CHECK   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESULT  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   central_q, central_d;
  logic [11:0]   radius_q, radius_d;
  logic [1:0]    mode_q, mode_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_count_q, res_count_d;
  logic [1:0]    res_err_q, res_err_d;

  logic          rng_ok;
  logic [CW-1:0] cnt_inc;

  // SET status is observed by the surrounding system, not acted on here.
  logic unused_set_busy;
  assign unused_set_busy = set_busy;

  // Every x/y coordinate must lie on the 1..8 grid; radii are unrestricted.
  always_comb begin
    rng_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (central_q[i*4 +: 4] == 4'd0 || central_q[i*4 +: 4] > 4'd8) begin
        rng_ok = 1'b0;
      end
    end
  end

  // The counter saturates, so it can never wrap back below the abort threshold.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    central_d   = central_q;
    radius_d    = radius_q;
    mode_d      = mode_q;
    res_valid_d = res_valid_q;
    res_count_d = res_count_q;
    res_err_d   = res_err_q;

    case (state_q)
      ST_COLLECT: begin
        // in_ready is high here, so in_valid alone marks a transfer.
        if (in_valid) begin
          case (idx_q)
            3'd0:    mode_d            = in_data[1:0];
            3'd1:    central_d[23:16]  = in_data;
            3'd2:    central_d[15:8]   = in_data;
            3'd3:    central_d[7:0]    = in_data;
            3'd4:    radius_d[11:4]    = in_data;
            3'd5:    radius_d[3:0]     = in_data[7:4];
            default: ;
          endcase
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_CHECK: begin
        if (CHECK_RNG && !rng_ok) begin
          res_valid_d = 1'b1;
          res_count_d = 8'd0;
          res_err_d   = 2'b01;
          state_d     = ST_RESULT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // A completion in the same cycle as the timeout takes priority.
        if (set_valid) begin
          res_valid_d = 1'b1;
          res_count_d = set_cand;
          res_err_d   = 2'b00;
          state_d     = ST_RESULT;
        end else if (cnt_inc == CNT_MAX) begin
          res_valid_d = 1'b1;
          res_count_d = 8'd0;
          res_err_d   = 2'b10;
          state_d     = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_COLLECT;
      idx_q       <= 3'd0;
      cnt_q       <= '0;
      central_q   <= 24'd0;
      radius_q    <= 12'd0;
      mode_q      <= 2'd0;
      res_valid_q <= 1'b0;
      res_count_q <= 8'd0;
      res_err_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      central_q   <= central_d;
      radius_q    <= radius_d;
      mode_q      <= mode_d;
      res_valid_q <= res_valid_d;
      res_count_q <= res_count_d;
      res_err_q   <= res_err_d;
    end
  end

  assign in_ready    = (state_q == ST_COLLECT);
  assign busy        = (state_q != ST_COLLECT);
  assign set_en      = (state_q == ST_ISSUE);
  assign set_central = central_q;
  assign set_radius  = radius_q;
  assign set_mode    = mode_q;
  assign res_valid   = res_valid_q;
  assign res_count   = res_count_q;
  assign res_err     = res_err_q;

endmodule

// File: tb/tb_set_cmd_loader.sv
// Purpose: directed bench for set_cmd_loader with a behavioural SET engine attached.
// Latency: SET model answers SET_LAT+1 cycles after set_en, or never when no_resp is set.
// Backpressure: res_ready is driven by the stimulus, including a long stall.
module tb_set_cmd_loader;

  localparam int TIMEOUT = 127;
  localparam int SET_LAT = 20;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_cand;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_count;
  logic [1:0]  res_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  set_cmd_loader #(.TIMEOUT(TIMEOUT), .CHECK_RNG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
    .set_busy(set_busy), .set_valid(set_valid), .set_cand(set_cand),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count), .res_err(res_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SET engine model ----------------
  // Modes: 0 = circle1, 1 = circle1 and circle2, 2 = exactly one of circle1/circle2,
  // 3 = all three circles. Counts lattice points on the 8x8 grid.
  function automatic int set_count(input logic [1:0] m, input logic [23:0] c, input logic [11:0] r);
    int cnt;
    int px [3];
    int py [3];
    int rr [3];
    bit in_c [3];
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      px[k] = int'(c[20 - 8*k +: 4]);
      py[k] = int'(c[16 - 8*k +: 4]);
      rr[k] = int'(r[8 - 4*k +: 4]);
    end
    for (int x = 1; x <= 8; x++) begin
      for (int y = 1; y <= 8; y++) begin
        for (int k = 0; k < 3; k++) begin
          in_c[k] = ((x - px[k]) * (x - px[k]) + (y - py[k]) * (y - py[k])) <= rr[k] * rr[k];
        end
        case (m)
          2'd0:    if (in_c[0]) cnt++;
          2'd1:    if (in_c[0] && in_c[1]) cnt++;
          2'd2:    if (in_c[0] != in_c[1]) cnt++;
          default: if (in_c[0] && in_c[1] && in_c[2]) cnt++;
        endcase
      end
    end
    return cnt;
  endfunction

  bit no_resp = 1'b0;
  int lat_cnt = 0;
  int proto_err = 0;

  initial begin
    set_busy  = 1'b0;
    set_valid = 1'b0;
    set_cand  = 8'd0;
  end

  always @(posedge clk) begin
    if (set_en) begin
      if (set_busy) proto_err++;
      set_valid <= 1'b0;
      set_busy  <= 1'b1;
      lat_cnt   <= SET_LAT;
      set_cand  <= 8'(set_count(set_mode, set_central, set_radius));
    end else if (set_busy) begin
      if (lat_cnt == 0) begin
        set_busy <= 1'b0;
        if (!no_resp) set_valid <= 1'b1;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // ---------------- event monitor ----------------
  int  cyc = 0;
  int  en_cnt = 0;
  int  en_cyc = 0;
  int  rv_cyc = 0;
  bit  rv_prev = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (set_en) begin
      en_cnt++;
      en_cyc = cyc;
    end
    if (res_valid && !rv_prev) rv_cyc = cyc;
    rv_prev = res_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called and returning on a negedge; the transfer happens on the intervening posedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("byte_accept_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [47:0] p);
    for (int i = 0; i < 6; i++) send_byte(p[47 - 8*i -: 8]);
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, res_valid}, 32'd1);
  endtask

  task automatic take_result(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_rv_clear"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_pkt(input string tag, input logic [47:0] p, input int exp_cnt,
                         input int exp_err, input int exp_en);
    int e0;
    e0 = en_cnt;
    send_pkt(p);
    wait_result({tag, "_done"});
    check({tag, "_count"}, {24'd0, res_count}, exp_cnt);
    check({tag, "_err"}, {30'd0, res_err}, exp_err);
    check({tag, "_en_pulses"}, en_cnt - e0, exp_en);
    take_result(tag);
  endtask

  // ---------------- stimulus ----------------
  int e_save;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_set_en",    {31'd0, set_en},    32'd0);
    check("rst_central",   {8'd0, set_central}, 32'd0);
    check("rst_radius",    {20'd0, set_radius}, 32'd0);
    check("rst_mode",      {30'd0, set_mode},  32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_count", {24'd0, res_count}, 32'd0);
    check("rst_res_err",   {30'd0, res_err},   32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Mode 0, circle1 at (4,4) r=2 -> 13 points. Circles 2/3 are on-grid points with r=0.
    e_save = en_cnt;
    send_pkt(48'h00_44_11_11_20_00);
    check("m0_central", {8'd0, set_central}, 32'h441111);
    check("m0_radius",  {20'd0, set_radius}, 32'h200);
    check("m0_busy",    {31'd0, busy},       32'd1);
    check("m0_in_ready_check", {31'd0, in_ready}, 32'd0);
    check("m0_en_in_check",    {31'd0, set_en},   32'd0);
    @(negedge clk);
    check("m0_en_two_cycles",  {31'd0, set_en},   32'd1);
    @(negedge clk);
    check("m0_en_one_cycle",   {31'd0, set_en},   32'd0);
    wait_result("m0_done");
    check("m0_count", {24'd0, res_count}, 32'd13);
    check("m0_err",   {30'd0, res_err},   32'd0);
    check("m0_en_pulses", en_cnt - e_save, 32'd1);
    take_result("m0");

    // x1 = 9 is off-grid: rejected without starting SET.
    run_pkt("rng", 48'h00_94_11_11_20_00, 0, 1, 0);

    // Identical circles: intersection is 13, exclusive region is empty.
    run_pkt("m1", 48'h01_44_44_11_22_00, 13, 0, 1);
    run_pkt("m2", 48'h02_44_44_11_22_00, 0, 0, 1);

    // SET never answers: abort exactly TIMEOUT+1 cycles after set_en.
    no_resp = 1'b1;
    run_pkt("tmo", 48'h00_44_11_11_20_00, 0, 2, 1);
    check("tmo_latency", rv_cyc - en_cyc, TIMEOUT + 1);
    no_resp = 1'b0;

    // Result stall: outputs frozen and input blocked while res_ready stays low.
    send_pkt(48'h01_44_44_11_22_00);
    wait_result("stall_done");
    in_valid = 1'b1;
    in_data  = 8'h03;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_res_valid", {31'd0, res_valid}, 32'd1);
      check("stall_res_count", {24'd0, res_count}, 32'd13);
      check("stall_res_err",   {30'd0, res_err},   32'd0);
      check("stall_mode",      {30'd0, set_mode},  32'd1);
      check("stall_in_ready",  {31'd0, in_ready},  32'd0);
    end
    // Byte still offered across the result handshake edge must not be taken.
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    in_valid  = 1'b0;
    check("stall_rv_clear",  {31'd0, res_valid}, 32'd0);
    check("stall_in_ready",  {31'd0, in_ready},  32'd1);
    check("stall_no_early_b0", {30'd0, set_mode}, 32'd1);

    // Back-to-back packets straight after the result transfer.
    run_pkt("b2b_a", 48'h00_44_11_11_20_00, 13, 0, 1);
    run_pkt("b2b_b", 48'h02_44_44_11_22_00, 0, 0, 1);

    // Reset after B3: partial packet discarded, no SET start.
    e_save = en_cnt;
    send_byte(8'h01);
    send_byte(8'h44);
    send_byte(8'h44);
    send_byte(8'h11);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mrst_busy",      {31'd0, busy},       32'd0);
    check("mrst_in_ready",  {31'd0, in_ready},   32'd1);
    check("mrst_central",   {8'd0, set_central}, 32'd0);
    check("mrst_mode",      {30'd0, set_mode},   32'd0);
    check("mrst_res_valid", {31'd0, res_valid},  32'd0);
    repeat (5) @(negedge clk);
    check("mrst_no_en", en_cnt - e_save, 32'd0);
    run_pkt("mrst_fresh", 48'h00_44_11_11_20_00, 13, 0, 1);

    check("set_protocol", proto_err, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
